regf_write_ctrl: RTL
====================

Name: regf_write_ctrl

Overview:
Write-port controller for the 32-entry, 5-bit-addressed register file. Arbitrates the single write port between NUM_REQ requesters (core writeback, load unit, security-config loader) using per-requester valid/ready handshakes and round-robin priority. After reset it first sequences a hardware clear of x1..x31 to zero. Its outputs drive the register file's write_en, rsW and write_data directly.

Parameters:
REGF_WIDTH, 32, data width of each register and each write.
NUM_REQ, 3, number of requesters (2..8).
CLEAR_ON_RESET, 1, 1 = run the x1..x31 clear sequence after reset; 0 = enter RUN directly.

Ports:
clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*5  packed destination register; requester i uses bits [5i+4:5i]
req_data  in  NUM_REQ*REGF_WIDTH  packed write data; requester i uses slice i
req_ready  out  NUM_REQ  one-hot (or zero) acceptance strobe
write_en  out  1  register-file write enable
rsW  out  5  register-file write address
write_data  out  REGF_WIDTH  register-file write data
grant_id  out  $clog2(NUM_REQ)  index of the requester whose write is on the outputs this cycle
init_done  out  1  high once the clear sequence has finished; stays high until reset

Behaviour:
- Reset (rst_n low at a clk edge): state = CLEAR (or RUN if CLEAR_ON_RESET=0), clear_idx = 1, rr_ptr = 0, write_en = 0, rsW = 0, write_data = 0, grant_id = 0, init_done = CLEAR_ON_RESET ? 0 : 1. Any in-flight registered write is discarded.
- FSM states:
  - CLEAR: each cycle registers write_en=1, rsW=clear_idx, write_data=0; clear_idx increments. After clear_idx=31 is issued, go to RUN and set init_done=1 on the same edge. Clear takes exactly 31 cycles. req_ready is all zeros in CLEAR.
  - RUN: arbitrate every cycle. There is no exit except reset.
- Arbitration (RUN): search req_valid starting at index rr_ptr and wrapping modulo NUM_REQ. The first asserted index g wins. req_ready[g]=1 in the same cycle, combinationally from req_valid and rr_ptr; all other ready bits are 0. A transfer occurs when valid&&ready; then rr_ptr <= (g+1) mod NUM_REQ. With no valid request, rr_ptr holds and req_ready=0.
- Handshake rules: a requester holds valid, addr and data stable until it sees ready. Valid must not depend on ready. At most one transfer per cycle.
- Latency: a transfer accepted at edge N produces write_en=1, rsW=addr, write_data=data and grant_id=g during cycle N+1. The register file commits the write at edge N+1. Sustained throughput is 1 write per cycle.
- Cycles with no transfer: write_en=0 next cycle; rsW, write_data and grant_id hold their previous values.
- x0 target: the request is accepted (ready asserted, rr_ptr advances), but write_en stays 0 for that slot. The write is dropped.
- Same-register conflicts: requests are serialized in grant order, so the later grant's data is final.
- Reset mid-CLEAR or mid-RUN: next-cycle outputs take reset values and the clear sequence restarts from x1.

Decomposition:
- Shared package regf_pkg: REGF_ADDR_W=5, REGF_DEPTH=32, REGF_ZERO_IDX=5'd0, typedef regf_addr_t (logic [4:0]), typedef enum logic {WC_CLEAR, WC_RUN} wctrl_state_e.
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant and encoded index). It is purely combinational and reusable for read-port sharing later.

Test Plan:
- Clear: release rst_n, no requests -> write_en=1 for 31 consecutive cycles with rsW 1..31 and write_data 0. init_done rises with the last issued write. Reg file reads x1..x31 = 0.
- Single write: in RUN, req0 valid, addr=5, data=0xDEADBEEF -> req_ready[0] the same cycle; next cycle write_en=1, rsW=5, write_data=0xDEADBEEF, grant_id=0; read_data1 with rs1=5 returns 0xDEADBEEF afterwards.
- Rotation: all 3 requesters valid continuously, addrs 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles, one write per cycle, no starvation.
- x0 drop: req1 addr=0, data=0x1234 -> req_ready[1]=1, write_en stays 0 the next cycle, rr_ptr advances to 2, x0 reads 0.
- Reset mid-clear: assert rst_n low at clear_idx=10 for 1 cycle -> write_en=0 the next cycle, then the clear restarts at rsW=1 and init_done stays 0 until 31 writes complete.
- Backpressure during CLEAR: req2 valid throughout the clear -> req_ready stays 0. The request is granted on the first RUN cycle and its write appears one cycle later.

Source files
------------

// File: rtl/regf_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// regf_pkg : shared register-file types and constants.  Rev 1.0
// ============================================================================
package regf_pkg;

   localparam int REGF_ADDR_W = 5;
   localparam int REGF_DEPTH  = 32;

   typedef logic [REGF_ADDR_W-1:0] regf_addr_t;

   localparam regf_addr_t REGF_ZERO_IDX  = 5'd0;
   localparam regf_addr_t REGF_FIRST_IDX = 5'd1;
   localparam regf_addr_t REGF_LAST_IDX  = 5'(REGF_DEPTH - 1);

   typedef enum logic {
      WC_CLEAR = 1'b0,
      WC_RUN   = 1'b1
   } wctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/regf_write_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin picker, search starts at ptr.  Rev 1.0
// ============================================================================
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [N-1:0] w_rot;
   logic [IW:0]  w_sum;
   logic         w_any;

   // Rotate so that bit 0 is the requester at ptr; lowest set bit then wins.
   assign w_rot = N'({req, req} >> ptr);

   always_comb begin
      w_sum = '0;
      w_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, ptr} + (IW+1)'(k);
            w_any = 1'b1;
         end
      end
      if (w_sum >= (IW+1)'(N)) begin
         w_sum = w_sum - (IW+1)'(N);
      end
   end

   assign grant_idx = w_sum[IW-1:0];
   assign grant     = w_any ? (N'(1) << grant_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/regf_write_ctrl.sv
`default_nettype none
// ============================================================================
// regf_write_ctrl : register-file write-port controller, post-reset clear
//                   of x1..x31 then round-robin arbitration.  Rev 1.0
// ============================================================================
module regf_write_ctrl
   import regf_pkg::*;
#(
   parameter int  REGF_WIDTH     = 32,
   parameter int  NUM_REQ        = 3,
   parameter bit  CLEAR_ON_RESET = 1'b1,
   localparam int GID_W          = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*5-1:0]          req_addr,
   input  logic [NUM_REQ*REGF_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          write_en,
   output logic [4:0]                    rsW,
   output logic [REGF_WIDTH-1:0]         write_data,
   output logic [GID_W-1:0]              grant_id,
   output logic                          init_done
);

   localparam wctrl_state_e RESET_STATE = CLEAR_ON_RESET ? WC_CLEAR : WC_RUN;

   wctrl_state_e            r_state,       w_state_nxt;
   regf_addr_t              r_clear_idx,   w_clear_idx_nxt;
   logic [GID_W-1:0]        r_rr_ptr,      w_rr_ptr_nxt;
   logic                    r_write_en,    w_write_en_nxt;
   regf_addr_t              r_rsW,         w_rsW_nxt;
   logic [REGF_WIDTH-1:0]   r_write_data,  w_write_data_nxt;
   logic [GID_W-1:0]        r_grant_id,    w_grant_id_nxt;
   logic                    r_init_done,   w_init_done_nxt;
   logic [NUM_REQ-1:0]      w_ready;

   logic [NUM_REQ-1:0]      w_grant;
   logic [GID_W-1:0]        w_grant_idx;
   logic                    w_xfer;
   regf_addr_t              w_addr [NUM_REQ];
   logic [REGF_WIDTH-1:0]   w_data [NUM_REQ];
   regf_addr_t              w_sel_addr;
   logic [REGF_WIDTH-1:0]   w_sel_data;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_addr[gi] = req_addr[gi*5 +: 5];
         assign w_data[gi] = req_data[gi*REGF_WIDTH +: REGF_WIDTH];
      end
   endgenerate

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (GID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   // A grant is only ever raised for a valid requester, so any grant is a transfer.
   assign w_xfer     = |w_grant;
   assign w_sel_addr = w_addr[w_grant_idx];
   assign w_sel_data = w_data[w_grant_idx];

   always_comb begin
      w_state_nxt      = r_state;
      w_clear_idx_nxt  = r_clear_idx;
      w_rr_ptr_nxt     = r_rr_ptr;
      w_write_en_nxt   = 1'b0;
      w_rsW_nxt        = r_rsW;
      w_write_data_nxt = r_write_data;
      w_grant_id_nxt   = r_grant_id;
      w_init_done_nxt  = r_init_done;
      w_ready          = '0;

      case (r_state)
         WC_CLEAR: begin
            w_write_en_nxt   = 1'b1;
            w_rsW_nxt        = r_clear_idx;
            w_write_data_nxt = '0;
            w_clear_idx_nxt  = r_clear_idx + 5'd1;
            if (r_clear_idx == REGF_LAST_IDX) begin
               w_state_nxt     = WC_RUN;
               w_init_done_nxt = 1'b1;
            end
         end
         WC_RUN: begin
            w_ready = w_grant;
            if (w_xfer) begin
               // Writes to x0 are consumed but never reach the register file.
               w_write_en_nxt   = (w_sel_addr != REGF_ZERO_IDX);
               w_rsW_nxt        = w_sel_addr;
               w_write_data_nxt = w_sel_data;
               w_grant_id_nxt   = w_grant_idx;
               w_rr_ptr_nxt     = (w_grant_idx == GID_W'(NUM_REQ - 1)) ? '0
                                                                        : w_grant_idx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = RESET_STATE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= RESET_STATE;
         r_clear_idx  <= REGF_FIRST_IDX;
         r_rr_ptr     <= '0;
         r_write_en   <= 1'b0;
         r_rsW        <= REGF_ZERO_IDX;
         r_write_data <= '0;
         r_grant_id   <= '0;
         r_init_done  <= ~CLEAR_ON_RESET;
      end else begin
         r_state      <= w_state_nxt;
         r_clear_idx  <= w_clear_idx_nxt;
         r_rr_ptr     <= w_rr_ptr_nxt;
         r_write_en   <= w_write_en_nxt;
         r_rsW        <= w_rsW_nxt;
         r_write_data <= w_write_data_nxt;
         r_grant_id   <= w_grant_id_nxt;
         r_init_done  <= w_init_done_nxt;
      end
   end

   assign req_ready  = w_ready;
   assign write_en   = r_write_en;
   assign rsW        = r_rsW;
   assign write_data = r_write_data;
   assign grant_id   = r_grant_id;
   assign init_done  = r_init_done;

endmodule
`default_nettype wire
